// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor controller.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit-counter width; never narrower than one bit so WIDTH=1 still has a counter.
  function automatic int cnt_w(input int width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_sub_ctrl_full_sub.sv
// One-bit full-subtractor cell: diff = a - b - z, borrow out when a < b + z.
module full_sub (
  input  logic a,
  input  logic b,
  input  logic z,
  output logic diff,
  output logic borrow
);

  assign diff   = a ^ b ^ z;
  assign borrow = (~a & b) | (~(a ^ b) & z);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor controller: A - B - bin, one bit per clock, LSB first.
// Optional two's-complement overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff_out,
  output logic             borrow_out,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);
  import serial_sub_pkg::*;

  localparam int CW = cnt_w(WIDTH);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_res;
  logic             r_brw;
  logic [CW-1:0]    r_cnt;
  logic             w_diff;
  logic             w_brw;
  logic             w_accept;
  logic             w_last;

  full_sub u_cell (
    .a      (r_a_sr[0]),
    .b      (r_b_sr[0]),
    .z      (r_brw),
    .diff   (w_diff),
    .borrow (w_brw)
  );

  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_next = RUN;
      RUN:     if (w_last)    w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    busy      = (r_state == RUN);
    out_valid = (r_state == DONE);
  end

  // Result bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr <= '0;
      r_b_sr <= '0;
      r_res  <= '0;
      r_brw  <= 1'b0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_a_sr <= a_in;
      r_b_sr <= b_in;
      r_res  <= '0;
      r_brw  <= bin;
      r_cnt  <= '0;
    end else if (r_state == RUN) begin
      r_a_sr <= r_a_sr >> 1;
      r_b_sr <= r_b_sr >> 1;
      r_res  <= (r_res >> 1) | (WIDTH'(w_diff) << (WIDTH - 1));
      r_brw  <= w_brw;
      r_cnt  <= r_cnt + CW'(1);
    end
  end

  assign diff_out   = r_res;
  assign borrow_out = r_brw;

`ifdef SERIAL_SUB_OVF_EN
  logic r_ab_ne;
  logic r_ovf;

  // On the last RUN cycle r_a_sr[0] is A[MSB] and w_diff is diff[MSB].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ab_ne <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_ab_ne <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
    end else if ((r_state == RUN) && w_last) begin
      r_ovf <= r_ab_ne & (w_diff ^ r_a_sr[0]);
    end
  end

  assign ovf = r_ovf;
`endif

endmodule
